// File: rtl/rf_pkg.sv
// Shared definitions for the regfile operand-fetch stage: default widths,
// the hardwired-zero register index and the writeback bundle.
package rf_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_SEL_BITS   = 5;
  localparam int unsigned PAYLOAD_WIDTH  = 64;

  localparam logic [REG_SEL_BITS-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                      en;
    logic [REG_SEL_BITS-1:0]   sel;
    logic [REG_DATA_WIDTH-1:0] data;
  } wb_t;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Bundle of decode request, writeback, regFile read and execute handshake
// signals seen by the operand-fetch stage (slave) and its environment (master).
interface regfile_operand_fetch_if #(
  parameter int unsigned REG_DATA_WIDTH = rf_pkg::REG_DATA_WIDTH,
  parameter int unsigned REG_SEL_BITS   = rf_pkg::REG_SEL_BITS,
  parameter int unsigned PAYLOAD_WIDTH  = rf_pkg::PAYLOAD_WIDTH
);
  logic                      req_valid;
  logic                      req_ready;
  logic [REG_SEL_BITS-1:0]   req_rs1;
  logic [REG_SEL_BITS-1:0]   req_rs2;
  logic [PAYLOAD_WIDTH-1:0]  req_payload;
  logic                      wb_en;
  logic [REG_SEL_BITS-1:0]   wb_sel;
  logic [REG_DATA_WIDTH-1:0] wb_data;
  logic [REG_SEL_BITS-1:0]   rf_read_sel1;
  logic [REG_SEL_BITS-1:0]   rf_read_sel2;
  logic [REG_DATA_WIDTH-1:0] rf_read_data1;
  logic [REG_DATA_WIDTH-1:0] rf_read_data2;
  logic                      out_valid;
  logic                      out_ready;
  logic [REG_DATA_WIDTH-1:0] out_rs1_data;
  logic [REG_DATA_WIDTH-1:0] out_rs2_data;
  logic [PAYLOAD_WIDTH-1:0]  out_payload;

  modport master (
    output req_valid, req_rs1, req_rs2, req_payload,
    output wb_en, wb_sel, wb_data,
    output rf_read_data1, rf_read_data2, out_ready,
    input  req_ready, rf_read_sel1, rf_read_sel2,
    input  out_valid, out_rs1_data, out_rs2_data, out_payload
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_payload,
    input  wb_en, wb_sel, wb_data,
    input  rf_read_data1, rf_read_data2, out_ready,
    output req_ready, rf_read_sel1, rf_read_sel2,
    output out_valid, out_rs1_data, out_rs2_data, out_payload
  );
endinterface

// File: rtl/rf_bypass_mux.sv
// Per-operand source select: hardwired zero, same-cycle writeback,
// captured collision data, then the regFile read port.
module rf_bypass_mux #(
  parameter int unsigned REG_DATA_WIDTH = rf_pkg::REG_DATA_WIDTH,
  parameter int unsigned REG_SEL_BITS   = rf_pkg::REG_SEL_BITS
) (
  input  logic [REG_SEL_BITS-1:0]   sel,
  input  logic                      wb_en,
  input  logic [REG_SEL_BITS-1:0]   wb_sel,
  input  logic [REG_DATA_WIDTH-1:0] wb_data,
  input  logic                      col,
  input  logic [REG_DATA_WIDTH-1:0] col_data,
  input  logic [REG_DATA_WIDTH-1:0] rf_data,
  output logic [REG_DATA_WIDTH-1:0] operand
);
  import rf_pkg::*;

  logic is_zero;
  logic wb_hit;

  always_comb begin
    is_zero = (sel == REG_SEL_BITS'(ZERO_REG));
    wb_hit  = wb_en && (wb_sel == sel) && !is_zero;
    if (is_zero)     operand = '0;
    else if (wb_hit) operand = wb_data;
    else if (col)    operand = col_data;
    else             operand = rf_data;
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage: S1 waits on the 1-cycle SRAM read, S2 holds operands
// for execute; both stages track writebacks so delivered operands are current.
module regfile_operand_fetch #(
  parameter int unsigned REG_DATA_WIDTH = rf_pkg::REG_DATA_WIDTH,
  parameter int unsigned REG_SEL_BITS   = rf_pkg::REG_SEL_BITS,
  parameter int unsigned PAYLOAD_WIDTH  = rf_pkg::PAYLOAD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_operand_fetch_if.slave bus
);
  import rf_pkg::*;

  localparam int unsigned DW = REG_DATA_WIDTH;
  localparam int unsigned SW = REG_SEL_BITS;
  localparam int unsigned PW = PAYLOAD_WIDTH;

  function automatic logic wb_hit(input logic en, input logic [SW-1:0] wsel,
                                  input logic [SW-1:0] sel);
    return en && (wsel == sel) && (sel != SW'(ZERO_REG));
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [SW-1:0] s1_rs1_q, s1_rs1_d, s1_rs2_q, s1_rs2_d;
  logic [PW-1:0] s1_payload_q, s1_payload_d;
  logic          col1_q, col1_d, col2_q, col2_d;
  logic [DW-1:0] col1_data_q, col1_data_d, col2_data_q, col2_data_d;

  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [DW-1:0] out_rs1_data_q, out_rs1_data_d, out_rs2_data_q, out_rs2_data_d;
  logic [PW-1:0] out_payload_q, out_payload_d;

  logic          accept, move;
  logic [SW-1:0] sel1, sel2;
  logic [DW-1:0] op1, op2;

  // req_ready is gated by reset so nothing is accepted and selects stay 0 while held
  assign move          = s1_valid_q && (!out_valid_q || bus.out_ready);
  assign bus.req_ready = reset && (!s1_valid_q || move);
  assign accept        = bus.req_valid && bus.req_ready;
  assign sel1          = accept ? bus.req_rs1 : s1_rs1_q;
  assign sel2          = accept ? bus.req_rs2 : s1_rs2_q;

  assign bus.rf_read_sel1 = sel1;
  assign bus.rf_read_sel2 = sel2;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = out_rs1_data_q;
  assign bus.out_rs2_data = out_rs2_data_q;
  assign bus.out_payload  = out_payload_q;

  rf_bypass_mux #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SW)) u_mux1 (
    .sel(s1_rs1_q), .wb_en(bus.wb_en), .wb_sel(bus.wb_sel), .wb_data(bus.wb_data),
    .col(col1_q), .col_data(col1_data_q), .rf_data(bus.rf_read_data1), .operand(op1)
  );

  rf_bypass_mux #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SW)) u_mux2 (
    .sel(s1_rs2_q), .wb_en(bus.wb_en), .wb_sel(bus.wb_sel), .wb_data(bus.wb_data),
    .col(col2_q), .col_data(col2_data_q), .rf_data(bus.rf_read_data2), .operand(op2)
  );

  always_comb begin
    s1_valid_d   = accept || (s1_valid_q && !move);
    s1_rs1_d     = sel1;
    s1_rs2_d     = sel2;
    s1_payload_d = accept ? bus.req_payload : s1_payload_q;
    // A write on the same edge as a read leaves the SRAM output undefined; keep its data
    col1_d       = wb_hit(bus.wb_en, bus.wb_sel, sel1);
    col2_d       = wb_hit(bus.wb_en, bus.wb_sel, sel2);
    col1_data_d  = col1_d ? bus.wb_data : col1_data_q;
    col2_data_d  = col2_d ? bus.wb_data : col2_data_q;

    out_valid_d    = out_valid_q;
    out_rs1_d      = out_rs1_q;
    out_rs2_d      = out_rs2_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_payload_d  = out_payload_q;
    if (move) begin
      out_valid_d    = 1'b1;
      out_rs1_d      = s1_rs1_q;
      out_rs2_d      = s1_rs2_q;
      out_rs1_data_d = op1;
      out_rs2_data_d = op2;
      out_payload_d  = s1_payload_q;
    end else if (out_valid_q) begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        if (wb_hit(bus.wb_en, bus.wb_sel, out_rs1_q)) out_rs1_data_d = bus.wb_data;
        if (wb_hit(bus.wb_en, bus.wb_sel, out_rs2_q)) out_rs2_data_d = bus.wb_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q     <= 1'b0;
      s1_rs1_q       <= '0;
      s1_rs2_q       <= '0;
      s1_payload_q   <= '0;
      col1_q         <= 1'b0;
      col2_q         <= 1'b0;
      col1_data_q    <= '0;
      col2_data_q    <= '0;
      out_valid_q    <= 1'b0;
      out_rs1_q      <= '0;
      out_rs2_q      <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_payload_q  <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_rs1_q       <= s1_rs1_d;
      s1_rs2_q       <= s1_rs2_d;
      s1_payload_q   <= s1_payload_d;
      col1_q         <= col1_d;
      col2_q         <= col2_d;
      col1_data_q    <= col1_data_d;
      col2_data_q    <= col2_data_d;
      out_valid_q    <= out_valid_d;
      out_rs1_q      <= out_rs1_d;
      out_rs2_q      <= out_rs2_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_payload_q  <= out_payload_d;
    end
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Scoreboard bench: accepted requests are queued; a monitor checks every
// presented output against an architectural register-file model.
module tb_regfile_operand_fetch;
  import rf_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned PW = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_operand_fetch_if #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SW), .PAYLOAD_WIDTH(PW)) bus ();

  regfile_operand_fetch #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SW), .PAYLOAD_WIDTH(PW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // SRAM regFile: 1-cycle sync read, garbage when read and write hit the same entry on one edge
  logic [DW-1:0] mem [32];
  always @(posedge clock) begin
    if (bus.wb_en && bus.wb_sel == bus.rf_read_sel1) bus.rf_read_data1 <= $urandom;
    else                                             bus.rf_read_data1 <= mem[bus.rf_read_sel1];
    if (bus.wb_en && bus.wb_sel == bus.rf_read_sel2) bus.rf_read_data2 <= $urandom;
    else                                             bus.rf_read_data2 <= mem[bus.rf_read_sel2];
    if (bus.wb_en) mem[bus.wb_sel] <= bus.wb_data;
  end

  // Architectural state: x0 is zero, every other write lands at its edge
  logic [DW-1:0] ref_rf [32];
  always @(posedge clock) begin
    if (bus.wb_en && bus.wb_sel != '0) ref_rf[bus.wb_sel] <= bus.wb_data;
  end

  function automatic logic [DW-1:0] ref_val(input logic [SW-1:0] rs);
    return (rs == '0) ? '0 : ref_rf[rs];
  endfunction

  typedef struct packed {
    logic [SW-1:0] rs1;
    logic [SW-1:0] rs2;
    logic [PW-1:0] payload;
  } req_t;

  req_t        exp_q [$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle 2 units after the edge, record acceptance just before the next edge
  task automatic cycle(input logic v, input logic [SW-1:0] r1, input logic [SW-1:0] r2,
                       input logic [PW-1:0] pl, input wb_t wb, input logic ordy);
    @(posedge clock);
    #2;
    bus.req_valid   = v;
    bus.req_rs1     = r1;
    bus.req_rs2     = r2;
    bus.req_payload = pl;
    bus.wb_en       = wb.en;
    bus.wb_sel      = wb.sel;
    bus.wb_data     = wb.data;
    bus.out_ready   = ordy;
    #5;
    if (reset && bus.req_valid && bus.req_ready)
      exp_q.push_back('{rs1: r1, rs2: r2, payload: pl});
  endtask

  function automatic wb_t wr(input logic [SW-1:0] sel, input logic [DW-1:0] data);
    return '{en: 1'b1, sel: sel, data: data};
  endfunction

  localparam wb_t NO_WB = '0;

  // Monitor: outputs must always equal current architectural values of the head request
  initial begin
    req_t e;
    forever begin
      @(posedge clock);
      #8;
      if (reset && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          check("out_payload",  64'(bus.out_payload),  64'(e.payload));
          check("out_rs1_data", 64'(bus.out_rs1_data), 64'(ref_val(e.rs1)));
          check("out_rs2_data", 64'(bus.out_rs2_data), 64'(ref_val(e.rs2)));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int unsigned guard;
    bus.req_valid   = 1'b0;
    bus.req_rs1     = '0;
    bus.req_rs2     = '0;
    bus.req_payload = '0;
    bus.wb_en       = 1'b0;
    bus.wb_sel      = '0;
    bus.wb_data     = '0;
    bus.out_ready   = 1'b1;

    repeat (2) @(posedge clock);
    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) cycle(1'b0, '0, '0, '0, wr(SW'(i), $urandom), 1'b1);

    // Basic read with x0 as second operand
    cycle(1'b0, '0, '0, '0, wr(5'd5, 32'hA5A5_0001), 1'b1);
    cycle(1'b1, 5'd5, 5'd0, 64'hCAFE_0002, NO_WB, 1'b1);
    cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);
    cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);
    #1;
    check("basic_valid",   64'(bus.out_valid),    64'd1);
    check("basic_rs1",     64'(bus.out_rs1_data), 64'h0000_0000_A5A5_0001);
    check("basic_rs2",     64'(bus.out_rs2_data), 64'd0);
    check("basic_payload", 64'(bus.out_payload),  64'hCAFE_0002);

    // Same-edge read/write collision
    cycle(1'b1, 5'd7, 5'd0, 64'h3, wr(5'd7, 32'h1234), 1'b1);
    cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);
    cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);
    #1;
    check("collision_rs1", 64'(bus.out_rs1_data), 64'h1234);

    // Write one cycle after the request
    cycle(1'b1, 5'd0, 5'd9, 64'h4, NO_WB, 1'b1);
    cycle(1'b0, '0, '0, '0, wr(5'd9, 32'hBEEF), 1'b1);
    cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);
    #1;
    check("late_fwd_rs2", 64'(bus.out_rs2_data), 64'hBEEF);

    // Writeback while S2 is stalled; S1 full so the third request is refused
    cycle(1'b1, 5'd3, 5'd4, 64'h5, NO_WB, 1'b0);
    cycle(1'b1, 5'd6, 5'd3, 64'h6, NO_WB, 1'b0);
    cycle(1'b1, 5'd8, 5'd8, 64'h7, wr(5'd3, 32'h55), 1'b0);
    check("stall_req_ready", 64'(bus.req_ready), 64'd0);
    cycle(1'b0, '0, '0, '0, NO_WB, 1'b0);
    #1;
    check("stall_rs1",       64'(bus.out_rs1_data), 64'h55);
    check("stall_req_ready2", 64'(bus.req_ready),   64'd0);
    repeat (3) cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);

    // Reset with both stages full
    cycle(1'b1, 5'd1, 5'd2, 64'h8, NO_WB, 1'b0);
    cycle(1'b1, 5'd3, 5'd4, 64'h9, NO_WB, 1'b0);
    cycle(1'b1, 5'd10, 5'd11, 64'hA, NO_WB, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #6;
    check("rst_out_valid", 64'(bus.out_valid),    64'd0);
    check("rst_sel1",      64'(bus.rf_read_sel1), 64'd0);
    check("rst_sel2",      64'(bus.rf_read_sel2), 64'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    #6;
    check("rel_req_ready", 64'(bus.req_ready), 64'd1);
    check("rel_out_valid", 64'(bus.out_valid), 64'd0);

    // 16 back-to-back requests, then a longer random mix
    for (int k = 0; k < 16; k++)
      cycle(1'b1, SW'($urandom_range(0, 7)), SW'($urandom_range(0, 7)), {$urandom, $urandom},
            '{en: 1'($urandom_range(0, 1)), sel: SW'($urandom_range(0, 7)), data: $urandom},
            1'($urandom_range(0, 1)));
    for (int k = 0; k < 300; k++)
      cycle(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 31)), SW'($urandom_range(0, 7)),
            {$urandom, $urandom},
            '{en: 1'($urandom_range(0, 1)), sel: SW'($urandom_range(0, 7)), data: $urandom},
            ($urandom_range(0, 3) != 0));

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      cycle(1'b0, '0, '0, '0, NO_WB, 1'b1);
      guard++;
    end
    @(posedge clock);
    #9;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
